// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter that owns the select of a shared 2:1 mux.
// Grants are one-hot, registered, and bounded to MAX_HOLD cycles while the other side waits.
module mux2_rr_arbiter #(
    parameter  int MAX_HOLD = 8,
    localparam int CNT_W    = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic             req_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic             busy,
    output logic [CNT_W-1:0] hold_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             sel_q, sel_d;
    logic             last_b_q, last_b_d;
    logic             gnt_a_q, gnt_b_q, busy_q;
    logic             at_max_s;

    assign at_max_s = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

    // Next-state arbitration: tie-break against the last owner, preempt a full tenure.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        sel_d      = sel_q;
        last_b_d   = last_b_q;

        case (state_q)
            IDLE: begin
                if (req_a && req_b) begin
                    state_d = last_b_q ? OWN_A : OWN_B;
                end else if (req_a) begin
                    state_d = OWN_A;
                end else if (req_b) begin
                    state_d = OWN_B;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN_A: begin
                if (!req_a) begin
                    state_d = req_b ? OWN_B : IDLE;
                end else if (req_b && at_max_s) begin
                    state_d = OWN_B;
                end else begin
                    state_d = OWN_A;
                end
            end
            OWN_B: begin
                if (!req_b) begin
                    state_d = req_a ? OWN_A : IDLE;
                end else if (req_a && at_max_s) begin
                    state_d = OWN_A;
                end else begin
                    state_d = OWN_B;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new owner restarts its tenure and takes the mux; sel is left alone in IDLE.
        if (state_d == IDLE) begin
            hold_cnt_d = {CNT_W{1'b0}};
        end else if (state_d != state_q) begin
            hold_cnt_d = {CNT_W{1'b0}};
            sel_d      = (state_d == OWN_B);
            last_b_d   = (state_d == OWN_B);
        end else if (!at_max_s) begin
            hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end else begin
            hold_cnt_d = hold_cnt_q;
        end
    end

    // State and output registers; outputs are decoded from the next state so they flop directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= {CNT_W{1'b0}};
            sel_q      <= 1'b0;
            last_b_q   <= 1'b1;
            gnt_a_q    <= 1'b0;
            gnt_b_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            sel_q      <= sel_d;
            last_b_q   <= last_b_d;
            gnt_a_q    <= (state_d == OWN_A);
            gnt_b_q    <= (state_d == OWN_B);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign gnt_a    = gnt_a_q;
    assign gnt_b    = gnt_b_q;
    assign sel      = sel_q;
    assign busy     = busy_q;
    assign hold_cnt = hold_cnt_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: MAX_HOLD=8 and MAX_HOLD=1 instances share stimulus and
// are each compared every cycle against an ownership/tenure reference model.
module tb_mux2_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic       gnt_a8, gnt_b8, sel8, busy8;
    logic [2:0] hold8;
    logic       gnt_a1, gnt_b1, sel1, busy1;
    logic [0:0] hold1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
        .gnt_a(gnt_a8), .gnt_b(gnt_b8), .sel(sel8), .busy(busy8), .hold_cnt(hold8)
    );

    mux2_rr_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
        .gnt_a(gnt_a1), .gnt_b(gnt_b1), .sel(sel1), .busy(busy1), .hold_cnt(hold1)
    );

    // owner: -1 nobody, 0 = A, 1 = B; tenure = cycles the owner has held so far, minus one
    typedef struct {
        int owner;
        int last;
        int tenure;
        int sel;
    } mdl_t;

    mdl_t m8, m1;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.owner = -1; m.last = 1; m.tenure = 0; m.sel = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_next(mdl_t m, bit ra, bit rb, int max_hold);
        mdl_t n = m;
        bit   r[2];
        int   want;
        r[0] = ra;
        r[1] = rb;
        if (m.owner < 0) begin
            if (ra && rb)  want = 1 - m.last;
            else if (ra)   want = 0;
            else if (rb)   want = 1;
            else           want = -1;
        end else begin
            int o = m.owner;
            if (!r[o])                                  want = r[1-o] ? 1 - o : -1;
            else if (r[1-o] && (m.tenure + 1 >= max_hold)) want = 1 - o;
            else                                        want = o;
        end
        if (want < 0) begin
            n.owner = -1; n.tenure = 0;
        end else if (want != m.owner) begin
            n.owner = want; n.last = want; n.sel = want; n.tenure = 0;
        end else begin
            n.tenure = (m.tenure + 1 > max_hold - 1) ? max_hold - 1 : m.tenure + 1;
        end
        return n;
    endfunction

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("gnt_a8", int'(gnt_a8), int'(m8.owner == 0));
        check_val("gnt_b8", int'(gnt_b8), int'(m8.owner == 1));
        check_val("sel8",   int'(sel8),   m8.sel);
        check_val("busy8",  int'(busy8),  int'(m8.owner >= 0));
        check_val("hold8",  int'(hold8),  m8.tenure);
        check_val("onehot8", int'(gnt_a8 & gnt_b8), 0);
        check_val("gnt_a1", int'(gnt_a1), int'(m1.owner == 0));
        check_val("gnt_b1", int'(gnt_b1), int'(m1.owner == 1));
        check_val("sel1",   int'(sel1),   m1.sel);
        check_val("busy1",  int'(busy1),  int'(m1.owner >= 0));
        check_val("hold1",  int'(hold1),  m1.tenure);
    endtask

    task automatic cycle(input bit ra, input bit rb);
        req_a = ra;
        req_b = rb;
        @(posedge clk);
        m8 = mdl_next(m8, ra, rb, 8);
        m1 = mdl_next(m1, ra, rb, 1);
        #1;
        check_all();
    endtask

    initial begin
        bit ra, rb;
        m8 = mdl_reset();
        m1 = mdl_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Simultaneous first requests: A wins the tie, then 8-cycle tenures alternate
        repeat (40) cycle(1'b1, 1'b1);
        repeat (2) cycle(1'b0, 1'b0);

        // A alone saturates its tenure, releases to IDLE; then a short B pulse
        repeat (20) cycle(1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0);

        // Direct handoff with no idle bubble
        repeat (4) cycle(1'b1, 1'b0);
        repeat (4) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0);

        // Random traffic: each request toggles with probability 1/4
        ra = 1'b0;
        rb = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3, 0) == 0) ra = ~ra;
            if ($urandom_range(3, 0) == 0) rb = ~rb;
            cycle(ra, rb);
        end

        // Asynchronous reset in the middle of a B tenure
        repeat (3) cycle(1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b1);
        check_val("pre_rst_gnt_b", int'(gnt_b8), 1);
        #2;
        rst_n = 1'b0;
        m8 = mdl_reset();
        m1 = mdl_reset();
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b1);
        check_val("post_rst_a_first", int'(gnt_a8), 1);
        repeat (12) cycle(1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
